lsu_ram_master: RTL
===================

// Module: lsu_ram_master
// PURPOSE
//  Load/store initiator that drives the byte-addressed little-endian data RAM.
//  The RAM port (ram_en/read_*/write_*) always moves 4 bytes, at addr..addr+3, with 1-cycle registered read latency.
//  Takes one CPU load/store request at a time and performs LB/LH/LW/LBU/LHU with sign/zero extension.
//  SB/SH are done as read-modify-write, because the RAM only supports 32-bit writes.
// PARAMETERS
//  ADDR_W   32   byte-address width of req_addr / read_addr / write_addr
// PORTS
//  clk         in   1        clock; all logic on posedge
//  rst         in   1        synchronous, active-high reset
//  req_valid   in   1        request present
//  req_ready   out  1        request accepted when req_valid && req_ready
//  req_we      in   1        1 = store, 0 = load
//  req_funct3  in   3        RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr    in   ADDR_W   byte address
//  req_wdata   in   `XLEN    store data (low byte/half used for SB/SH)
//  resp_valid  out  1        one-cycle completion pulse
//  resp_rdata  out  `XLEN    extended load data; 0 for stores
//  resp_err    out  1        misalign error (see CONFIGURATION)
//  ram_en      out  1        RAM enable
//  read_flag   out  1        `READ_ENABLE when reading
//  read_addr   out  ADDR_W   RAM read byte address
//  read_data   in   `XLEN    RAM data, valid the cycle after read issue
//  write_flag  out  1        `WRITE_ENABLE when writing
//  write_addr  out  ADDR_W   RAM write byte address
//  write_data  out  `XLEN    RAM write word
// BEHAVIOUR
//  States: IDLE, RD, MERGE, WR, DONE.
//   - On accept, addr/wdata/we/funct3 are registered.
//   - Transitions:
//       IDLE -> RD            load, SB or SH
//       IDLE -> WR            SW
//       RD   -> DONE          load
//       RD   -> MERGE         SB/SH
//       MERGE -> WR
//       WR   -> DONE
//       DONE -> IDLE
//  req_ready=1 only in IDLE; at most one request in flight; no response queue.
//  RAM strobes are decoded from the state register only (no comb path from req_*), and are forced 0 while rst=1.
//   - RD: ram_en=1, read_flag=`READ_ENABLE, read_addr=addr_q.
//   - WR: ram_en=1, write_flag=`WRITE_ENABLE, write_addr=addr_q.
//   - All other states: ram_en=0, both flags deasserted, addresses and write_data held.
//  Load: in DONE, resp_rdata is built from read_data:
//   - LB:  sign-extend [7:0];   LBU: zero-extend [7:0]
//   - LH:  sign-extend [15:0];  LHU: zero-extend [15:0]
//   - LW:  full word
//   - funct3 011/110/111: treated as LW.
//  SB/SH:
//   - MERGE registers read_data with byte 0 (SB) or bytes 0-1 (SH) replaced by wdata_q.
//   - WR writes that word back, so bytes addr+1..addr+3 (SB) or addr+2..addr+3 (SH) keep their prior values.
//   - Store funct3[1:0]=11 is treated as SW.
//  Latency from accept edge to the resp_valid cycle: load 2, SW 2, SB/SH 4. Back-to-back accept earliest the cycle after DONE.
//  Addresses pass through unchanged; no alignment or wrap handling. addr+1..+3 wrap is RAM-defined.
//  Reset (any state, including mid-RMW): next state IDLE; resp_valid=0, resp_rdata=0, resp_err=0; no RAM write during or after the reset cycle.
//   - req_ready=0 while rst=1, and 1 the first cycle after release.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined:
//   - Rejected requests: H/HU with addr[0]!=0, or W with addr[1:0]!=0.
//   - A rejected request goes IDLE->DONE with no RAM access: resp_valid=1 and resp_err=1 one cycle after accept, resp_rdata=0.
//  Macro undefined:
//   - No check; every address is accessed as-is; resp_err is tied to 0.
// STRUCTURE
//  Shared config header: existing `XLEN, `READ_ENABLE, `WRITE_ENABLE, `ZERO_32BIT.
//   - Add `LSU_F3_B/H/W/BU/HU funct3 codes, for decode and CPU use.
//  FSM state encoding is local (localparam).
//  Sub-module lsu_load_ext: combinational funct3 + word -> extended `XLEN; reused by the CPU writeback path.
// TESTING
//  1 rst=1 for 2 cycles mid-SB (assert in MERGE) -> write_flag never asserted, resp_valid=0, req_ready=1 the cycle after release.
//  2 SW 0x10=0xDEADBEEF, then LW 0x10:
//      -> RAM write of bytes EF,BE,AD,DE at 0x10..0x13; resp_valid 2 cycles after accept; resp_rdata=0xDEADBEEF.
//  3 Preset byte 0x14=0x5A; SB 0x11 wdata=0x123456A5; LW 0x10 -> 0xDEADA5EF; LW 0x14 low byte still 0x5A; SB latency 4.
//  4 From state of test 3:
//      LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
//  5 req_valid held high across busy cycles -> exactly one accept per IDLE.
//      Second request is accepted the cycle after DONE with its own address.
//  6 LSU_MISALIGN_CHECK_EN: LH 0x13 -> resp_err=1 at +1 cycle, ram_en stays 0; same request without macro -> normal 2-cycle load.

Source files
------------

// File: rtl/lsu_ram_master_pkg.sv
// lsu_ram_master_pkg: shared config macros, funct3 codes and misalign helper; LSU_MISALIGN_CHECK_EN enables misaligned H/W rejection
`ifndef LSU_CFG_DEFS
`define LSU_CFG_DEFS
`define XLEN 32
`define READ_ENABLE 1'b1
`define WRITE_ENABLE 1'b1
`define ZERO_32BIT 32'h0
`define LSU_F3_B 3'b000
`define LSU_F3_H 3'b001
`define LSU_F3_W 3'b010
`define LSU_F3_BU 3'b100
`define LSU_F3_HU 3'b101
`endif
package lsu_ram_master_pkg;
  typedef logic [`XLEN-1:0] word_t;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return f3[1] ? (a != 2'b00) : (f3[0] & a[0]);
  endfunction
endpackage

// File: rtl/lsu_ram_master_if.sv
// lsu_ram_master_if: CPU request/response handshake and 32-bit RAM port of the load/store unit
interface lsu_ram_master_if #(parameter int ADDR_W = 32);
  logic req_valid, req_ready, req_we;
  logic [2:0] req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [`XLEN-1:0] req_wdata;
  logic resp_valid, resp_err;
  logic [`XLEN-1:0] resp_rdata;
  logic ram_en, read_flag, write_flag;
  logic [ADDR_W-1:0] read_addr, write_addr;
  logic [`XLEN-1:0] read_data, write_data;
  modport master(input req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
                 output req_ready, resp_valid, resp_rdata, resp_err, ram_en, read_flag, write_flag,
                 read_addr, write_addr, write_data);
  modport slave(output req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
                input req_ready, resp_valid, resp_rdata, resp_err, ram_en, read_flag, write_flag,
                read_addr, write_addr, write_data);
endinterface

// File: rtl/lsu_ram_master_load_ext.sv
// lsu_load_ext: sign/zero-extends a loaded RAM word according to RV32I funct3
module lsu_load_ext
  import lsu_ram_master_pkg::*;
(
  input  logic [2:0] funct3,
  input  word_t      word,
  output word_t      data
);
  always_comb
    data = funct3 == `LSU_F3_B  ? {{(`XLEN-8){word[7]}}, word[7:0]} :
           funct3 == `LSU_F3_BU ? {{(`XLEN-8){1'b0}}, word[7:0]} :
           funct3 == `LSU_F3_H  ? {{(`XLEN-16){word[15]}}, word[15:0]} :
           funct3 == `LSU_F3_HU ? {{(`XLEN-16){1'b0}}, word[15:0]} : word;
endmodule

// File: rtl/lsu_ram_master.sv
// lsu_ram_master: one-at-a-time load/store initiator; SB/SH via read-modify-write; LSU_MISALIGN_CHECK_EN rejects misaligned H/W
module lsu_ram_master
  import lsu_ram_master_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  lsu_ram_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  word_t wr_word, ext;
  logic we_q, err_q, req_err;
  logic [2:0] f3_q;
  lsu_load_ext u_ext (.funct3(f3_q), .word(bus.read_data), .data(ext));
`ifdef LSU_MISALIGN_CHECK_EN
  always_comb req_err = misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  always_comb req_err = 1'b0;
`endif
  // wr_word holds the store data until MERGE folds the untouched upper bytes in
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else
      case (state)
        IDLE: if (bus.req_valid) begin
          addr_q  <= bus.req_addr;
          wr_word <= bus.req_wdata;
          we_q    <= bus.req_we;
          f3_q    <= bus.req_funct3;
          err_q   <= req_err;
          state   <= req_err ? DONE : (bus.req_we && bus.req_funct3[1]) ? WR : RD;
        end
        RD: state <= we_q ? MERGE : DONE;
        MERGE: begin
          wr_word <= {bus.read_data[`XLEN-1:16], f3_q[0] ? wr_word[15:8] : bus.read_data[15:8], wr_word[7:0]};
          state   <= WR;
        end
        WR: state <= DONE;
        default: state <= IDLE;
      endcase
  always_comb begin
    bus.req_ready  = !rst && state == IDLE;
    bus.ram_en     = !rst && (state == RD || state == WR);
    bus.read_flag  = (!rst && state == RD) ? `READ_ENABLE : ~`READ_ENABLE;
    bus.write_flag = (!rst && state == WR) ? `WRITE_ENABLE : ~`WRITE_ENABLE;
    bus.read_addr  = addr_q;
    bus.write_addr = addr_q;
    bus.write_data = wr_word;
    bus.resp_valid = !rst && state == DONE;
    bus.resp_err   = bus.resp_valid && err_q;
    bus.resp_rdata = (bus.resp_valid && !we_q && !err_q) ? ext : `ZERO_32BIT;
  end
endmodule
